// File: rtl/cfu_mac_sequencer.sv
// Dot-product sequencer for a CFU MAC: streams weights against a recirculating activation buffer
// and accumulates the MAC result, with a stall timeout that ends the run with an error flag.
module cfu_mac_sequencer #(
   parameter int unsigned LEN_W   = 9,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [LEN_W-1:0] length,
   input  logic             abort,
   input  logic             weight_valid,
   output logic             weight_ready,
   input  logic [31:0]      weight_data,
   input  logic             buf_read_valid,
   input  logic [31:0]      buf_read_data,
   output logic             buf_read_en,
   output logic             buf_write_en,
   output logic [31:0]      buf_write_data,
   output logic [31:0]      mac_a,
   output logic [31:0]      mac_b,
   input  logic [31:0]      mac_sum,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [31:0]      result
);

   localparam int unsigned STALL_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   state_e             r_state,     w_state_d;
   logic [31:0]        r_acc,       w_acc_d;
   logic [LEN_W-1:0]   r_remaining, w_remaining_d;
   logic [STALL_W-1:0] r_stall_cnt, w_stall_d;
   logic               r_error,     w_error_d;
   logic               w_step;

   // Strobes are suppressed by abort and reset so nothing is consumed in a cycle being discarded.
   assign w_step = (r_state == StRun) & weight_valid & buf_read_valid & ~abort & ~reset;

   assign weight_ready   = w_step;
   assign buf_read_en    = w_step;
   assign buf_write_en   = w_step;
   assign buf_write_data = buf_read_data;
   assign mac_a          = weight_data;
   assign mac_b          = buf_read_data;
   assign busy           = (r_state != StIdle);
   assign done           = (r_state == StDone);
   assign error          = r_error;
   assign result         = r_acc;

   always_comb begin
      w_state_d     = r_state;
      w_acc_d       = r_acc;
      w_remaining_d = r_remaining;
      w_stall_d     = r_stall_cnt;
      w_error_d     = r_error;
      if (abort) begin
         w_state_d = StIdle;
      end else begin
         case (r_state)
            StIdle: begin
               if (start) begin
                  w_acc_d   = '0;
                  w_error_d = 1'b0;
                  if (length != '0) begin
                     w_remaining_d = length;
                     w_stall_d     = '0;
                     w_state_d     = StRun;
                  end else begin
                     w_state_d = StDone;
                  end
               end
            end
            StRun: begin
               if (w_step) begin
                  w_acc_d       = r_acc + mac_sum;
                  w_remaining_d = r_remaining - LEN_W'(1);
                  w_stall_d     = '0;
                  if (r_remaining == LEN_W'(1)) begin
                     w_state_d = StDone;
                  end
               end else begin
                  w_stall_d = r_stall_cnt + STALL_W'(1);
                  if (w_stall_d == STALL_MAX) begin
                     w_state_d = StDone;
                     w_error_d = 1'b1;
                  end
               end
            end
            StDone: begin
               w_state_d = StIdle;
            end
            default: begin
               w_state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= StIdle;
         r_acc       <= '0;
         r_remaining <= '0;
         r_stall_cnt <= '0;
         r_error     <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_acc       <= w_acc_d;
         r_remaining <= w_remaining_d;
         r_stall_cnt <= w_stall_d;
         r_error     <= w_error_d;
      end
   end

endmodule

// File: tb/tb_cfu_mac_sequencer.sv
// Self-checking bench for cfu_mac_sequencer: a queue-backed FWFT buffer and weight source,
// a directed vector table, hand-written corner sequences and randomized runs against a sum model.
module tb_cfu_mac_sequencer;

   localparam int unsigned LEN_W = 9;
   localparam int unsigned TO    = 8;

   logic             clk = 1'b0;
   logic             reset, start, abort;
   logic [LEN_W-1:0] length;
   logic             weight_valid, weight_ready, buf_read_valid;
   logic             buf_read_en, buf_write_en, busy, done, error;
   logic [31:0]      weight_data, buf_read_data, buf_write_data;
   logic [31:0]      mac_a, mac_b, mac_sum, result;

   always #5 clk = ~clk;

   cfu_mac_sequencer #(.LEN_W(LEN_W), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .start(start), .length(length), .abort(abort),
      .weight_valid(weight_valid), .weight_ready(weight_ready), .weight_data(weight_data),
      .buf_read_valid(buf_read_valid), .buf_read_data(buf_read_data),
      .buf_read_en(buf_read_en), .buf_write_en(buf_write_en), .buf_write_data(buf_write_data),
      .mac_a(mac_a), .mac_b(mac_b), .mac_sum(mac_sum),
      .busy(busy), .done(done), .error(error), .result(result)
   );

   // MAC environment: product plus offset, or a forced value for the wrap test.
   logic        mac_ovr = 1'b0;
   logic [31:0] mac_ovr_val = '0, mac_off = '0;
   assign mac_sum = mac_ovr ? mac_ovr_val : (mac_a * mac_b + mac_off);

   logic [31:0] buf_q[$], b_load[$], wq[$], w_load[$];
   int          b_seq = 0, b_seen = 0, w_seq = 0, w_seen = 0, gap = 0;
   logic        b_has = 1'b0, w_has = 1'b0;
   logic [31:0] b_head = '0, w_head = '0;
   logic        w_man = 1'b1, b_man = 1'b1, w_rg = 1'b1, b_rg = 1'b1, rand_mode = 1'b0;

   assign weight_valid   = w_has & (rand_mode ? w_rg : w_man);
   assign weight_data    = w_head;
   assign buf_read_valid = b_has & (rand_mode ? b_rg : b_man);
   assign buf_read_data  = b_head;

   // Monitor: samples strobes mid-cycle and keeps event history for the checks.
   int          cyc = 0, n_done = 0, viol = 0, done_cyc = 0, start_cyc = 0;
   int          step_cycs[$];
   logic        s_ren = 1'b0, s_wen = 1'b0, s_wrdy = 1'b0;
   logic [31:0] s_wdata = '0;

   always @(negedge clk) begin
      cyc++;
      if (buf_read_en && !buf_read_valid) viol++;
      if (weight_ready && !weight_valid) viol++;
      if (weight_ready != buf_read_en || buf_write_en != buf_read_en) viol++;
      if (buf_write_en && buf_write_data !== buf_read_data) viol++;
      if (buf_read_en) step_cycs.push_back(cyc);
      if (done) begin
         n_done++;
         done_cyc = cyc;
      end
      if (start && !busy && !reset && !abort) start_cyc = cyc;
      s_ren   = buf_read_en;
      s_wen   = buf_write_en;
      s_wrdy  = weight_ready;
      s_wdata = buf_write_data;
   end

   // Source/sink model, updated just after each rising edge.
   always begin
      @(posedge clk);
      #1;
      if (b_seq != b_seen) begin
         buf_q  = b_load;
         b_seen = b_seq;
      end else begin
         if (s_ren && buf_q.size() > 0) void'(buf_q.pop_front());
         if (s_wen) buf_q.push_back(s_wdata);
      end
      if (w_seq != w_seen) begin
         wq     = w_load;
         w_seen = w_seq;
      end else if (s_wrdy && wq.size() > 0) begin
         void'(wq.pop_front());
      end
      b_has  = (buf_q.size() != 0);
      b_head = b_has ? buf_q[0] : '0;
      w_has  = (wq.size() != 0);
      w_head = w_has ? wq[0] : '0;
      if (rand_mode) begin
         if (gap < 4 && $urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 2))
               0:       begin w_rg = 1'b0; b_rg = 1'b1; end
               1:       begin w_rg = 1'b1; b_rg = 1'b0; end
               default: begin w_rg = 1'b0; b_rg = 1'b0; end
            endcase
            gap++;
         end else begin
            w_rg = 1'b1;
            b_rg = 1'b1;
            gap  = 0;
         end
      end
   end

   int n_checks = 0, n_fail = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input int len);
      start  = 1'b1;
      length = LEN_W'(len);
      tick();
      start  = 1'b0;
   endtask

   task automatic wait_done(input string name, input int bound);
      bit seen = 1'b0;
      for (int k = 0; k < bound && !seen; k++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check({name, "_done_seen"}, 32'(seen), 32'd1);
      tick();
   endtask

   task automatic load3(input int a, input int b, input int c);
      b_load = {};
      b_load.push_back(a);
      b_load.push_back(b);
      b_load.push_back(c);
      b_seq++;
   endtask

   task automatic load_w(input int base, input int n);
      w_load = {};
      for (int i = 0; i < n; i++) w_load.push_back(base + i);
      w_seq++;
   endtask

   typedef struct {
      int len;
      int b0;
      int b1;
      int b2;
      int wbase;
      int off;
      int exp_res;
   } vec_t;

   vec_t        vt[5];
   int          s0, d0, bb[3], nb, len;
   logic [31:0] bv[$], wv[$], exp_acc, off;
   int          bad;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      vt[0] = '{3, 1, 2, 3, 4, 0, 32};
      vt[1] = '{0, 1, 2, 3, 4, 0, 0};
      vt[2] = '{5, 1, 2, 3, 1, 0, 28};
      vt[3] = '{2, -3, 7, 0, -2, 10, 19};
      vt[4] = '{1, 5, 0, 0, 100, -1, 499};

      reset = 1'b1; start = 1'b0; abort = 1'b0; length = '0;
      repeat (3) tick();
      @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_error", 32'(error), 0);
      check("rst_result", result, 0);
      check("rst_strobes", {29'd0, weight_ready, buf_read_en, buf_write_en}, 0);
      tick();
      reset = 1'b0;

      // Directed table, back-to-back operands.
      for (int i = 0; i < 5; i++) begin
         mac_off = vt[i].off;
         load3(vt[i].b0, vt[i].b1, vt[i].b2);
         load_w(vt[i].wbase, vt[i].len);
         tick(); tick();
         s0 = step_cycs.size();
         d0 = n_done;
         start_run(vt[i].len);
         wait_done($sformatf("vec%0d", i), 50);
         check($sformatf("vec%0d_result", i), result, vt[i].exp_res);
         check($sformatf("vec%0d_error", i), 32'(error), 0);
         check($sformatf("vec%0d_steps", i), step_cycs.size() - s0, vt[i].len);
         check($sformatf("vec%0d_done_pulses", i), n_done - d0, 1);
         if (vt[i].len == 0) begin
            check($sformatf("vec%0d_done_cycle", i), done_cyc, start_cyc + 1);
         end else begin
            check($sformatf("vec%0d_done_cycle", i), done_cyc, step_cycs[$] + 1);
            check($sformatf("vec%0d_back_to_back", i), step_cycs[$] - step_cycs[s0],
                  vt[i].len - 1);
         end
         bb = '{vt[i].b0, vt[i].b1, vt[i].b2};
         for (int k = 0; k < 3; k++)
            check($sformatf("vec%0d_buf%0d", i, k), buf_q[k], bb[(k + vt[i].len) % 3]);
      end

      // Weight gap of 3 cycles after step 2, with an ignored start during the gap.
      mac_off = 1;
      load3(2, -1, 4);
      load_w(3, 0);
      w_load = {32'd3, 32'd5, 32'd7, 32'd9};
      tick(); tick();
      s0 = step_cycs.size();
      start_run(4);
      tick();
      tick();
      w_man  = 1'b0;
      start  = 1'b1;
      length = LEN_W'(9);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("gap%0d_busy", k), 32'(busy), 1);
         check($sformatf("gap%0d_strobe", k), {30'd0, weight_ready, buf_read_en}, 0);
         tick();
         start = 1'b0;
      end
      w_man = 1'b1;
      wait_done("gap", 50);
      check("gap_result", result, 51);
      check("gap_error", 32'(error), 0);
      check("gap_steps", step_cycs.size() - s0, 4);
      check("gap_spacing", step_cycs[s0 + 2] - step_cycs[s0 + 1], 4);

      // Timeout after one step.
      mac_off = 0;
      load3(3, 3, 3);
      load_w(7, 1);
      tick(); tick();
      s0 = step_cycs.size();
      start_run(2);
      wait_done("tmo", 40);
      check("tmo_error", 32'(error), 1);
      check("tmo_result", result, 21);
      check("tmo_steps", step_cycs.size() - s0, 1);
      check("tmo_latency", done_cyc - step_cycs[$], TO + 1);
      tick();
      check("tmo_error_held", 32'(error), 1);
      start_run(0);
      check("tmo_error_cleared", 32'(error), 0);
      wait_done("tmo_clr", 10);

      // Accumulator wrap.
      mac_ovr     = 1'b1;
      mac_ovr_val = 32'h7FFF_FFFF;
      load3(1, 1, 1);
      load_w(1, 2);
      tick(); tick();
      start_run(2);
      tick();
      mac_ovr_val = 32'd1;
      wait_done("wrap", 20);
      check("wrap_result", result, 32'h8000_0000);
      mac_ovr = 1'b0;

      // Reset (mode 1) or abort (mode 0) after step 2 of 5, then a clean full run.
      for (int mode = 0; mode < 2; mode++) begin
         load3(1, 2, 3);
         load_w(1, 5);
         tick(); tick();
         start_run(5);
         tick();
         tick();
         if (mode == 1) reset = 1'b1;
         else abort = 1'b1;
         d0 = n_done;
         s0 = step_cycs.size();
         @(negedge clk);
         check($sformatf("int%0d_no_step", mode), 32'(weight_ready), 0);
         tick();
         reset = 1'b0;
         abort = 1'b0;
         @(negedge clk);
         check($sformatf("int%0d_idle", mode), 32'(busy), 0);
         check($sformatf("int%0d_result", mode), result, (mode == 1) ? 32'd0 : 32'd5);
         tick(); tick(); tick();
         check($sformatf("int%0d_no_done", mode), n_done - d0, 0);
         check($sformatf("int%0d_no_more_steps", mode), step_cycs.size() - s0, 0);
         load3(1, 2, 3);
         load_w(1, 5);
         tick(); tick();
         s0 = step_cycs.size();
         start_run(5);
         wait_done($sformatf("int%0d_rerun", mode), 30);
         check($sformatf("int%0d_rerun_result", mode), result, 28);
         check($sformatf("int%0d_rerun_steps", mode), step_cycs.size() - s0, 5);
      end

      // Randomized runs with random stalls against a plain sum-of-products model.
      rand_mode = 1'b1;
      for (int r = 0; r < 10; r++) begin
         nb  = $urandom_range(1, 6);
         len = $urandom_range(1, 12);
         off = $urandom;
         bv  = {};
         wv  = {};
         for (int k = 0; k < nb; k++) bv.push_back($urandom);
         for (int k = 0; k < len; k++) wv.push_back($urandom);
         exp_acc = '0;
         for (int k = 0; k < len; k++) exp_acc = exp_acc + wv[k] * bv[k % nb] + off;
         mac_off = off;
         b_load  = bv;
         b_seq++;
         w_load  = wv;
         w_seq++;
         tick(); tick();
         s0 = step_cycs.size();
         start_run(len);
         wait_done($sformatf("rnd%0d", r), 200);
         check($sformatf("rnd%0d_result", r), result, exp_acc);
         check($sformatf("rnd%0d_error", r), 32'(error), 0);
         check($sformatf("rnd%0d_steps", r), step_cycs.size() - s0, len);
         bad = (buf_q.size() != nb) ? 1 : 0;
         for (int k = 0; k < nb && bad == 0; k++)
            if (buf_q[k] !== bv[(k + len) % nb]) bad++;
         check($sformatf("rnd%0d_buf_order", r), bad, 0);
      end
      rand_mode = 1'b0;

      check("strobe_rules", viol, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cfu_mac_sequencer.md
CFU_MAC_SEQUENCER -- requirements
Module: cfu_mac_sequencer

Interface
REQ-001 Parameter LEN_W, default 9, width of the length and remaining-count fields (max 2^LEN_W-1 steps).
REQ-002 Parameter TIMEOUT, default 255, maximum consecutive stall cycles in RUN before abort-with-error.
REQ-003 clk  input  1  single clock; every register updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a dot product; honoured only in IDLE.
REQ-006 length  input  LEN_W  number of MAC steps; sampled when start is honoured.
REQ-007 abort  input  1  returns to IDLE from any state on the next edge.
REQ-008 weight_valid / weight_ready  input / output  1 / 1  valid-ready handshake for weight words.
REQ-009 weight_data  input  32  signed weight word, qualified by weight_valid.
REQ-010 buf_read_valid  input  1  input buffer head is valid (first-word-fall-through).
REQ-011 buf_read_data  input  32  signed activation at buffer head.
REQ-012 buf_read_en / buf_write_en  output / output  1 / 1  pop the head / push a word into the input buffer.
REQ-013 buf_write_data  output  32  word pushed into the buffer; always equals buf_read_data.
REQ-014 mac_a / mac_b  output / output  32 / 32  MAC operands; combinationally weight_data / buf_read_data.
REQ-015 mac_sum  input  32  combinational MAC result for the current operands, offset already applied.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse marking a finished or timed-out run.
REQ-018 error  output  1  registered; set on timeout, cleared by the next honoured start.
REQ-019 result  output  32  registered accumulator value; holds after done until the next honoured start.

Function
REQ-020 States are IDLE, RUN and DONE; reset and abort force IDLE.
REQ-021 In IDLE, start=1 with length>0 loads remaining=length, clears the accumulator, clears stall_cnt and error, and enters RUN.
REQ-022 In IDLE, start=1 with length=0 clears the accumulator and error and enters DONE; no step occurs.
REQ-023 A step occurs in a RUN cycle with weight_valid=1 and buf_read_valid=1 and no abort.
REQ-024 In a step cycle, weight_ready, buf_read_en and buf_write_en are 1 in that same cycle.
REQ-025 In a step cycle, the buffer head is popped and re-pushed in the same cycle, so the activation vector is preserved for later filter sets.
REQ-026 In a step cycle, the accumulator is updated to acc + mac_sum, and remaining and stall_cnt are updated as specified below.
REQ-027 Accumulation is wraparound two's-complement modulo 2^32, with no saturation.
REQ-028 Outside step cycles, weight_ready, buf_read_en and buf_write_en are 0.
REQ-029 Throughput is one step per cycle, and a step in cycle N is visible in result at N+1.
REQ-030 remaining decrements on each step; the step that takes remaining from 1 to 0 moves the state to DONE.
REQ-031 In RUN, a non-step cycle increments stall_cnt and a step cycle resets it to 0.
REQ-032 When stall_cnt reaches TIMEOUT in RUN, the state moves to DONE with error=1 and the partial sum held in result.
REQ-033 DONE lasts exactly one cycle with done=1, then returns to IDLE.
REQ-034 start while busy is ignored, and length is not resampled.
REQ-035 abort has priority over start, a step and timeout in the same cycle: no step occurs, done is not pulsed, and result and error keep their values.
REQ-036 buf_read_en without buf_read_valid never occurs.

Reset
REQ-037 Reset, valid in any state including mid-run, forces: state=IDLE, busy=0, done=0, error=0, result=0, remaining=0, stall_cnt=0, weight_ready=0, buf_read_en=0, buf_write_en=0.
REQ-038 Reset has priority over abort, start and a step in the same cycle.

Verification
REQ-039 Buffer [1,2,3], offset 0 in the MAC, start with length=3, weights [4,5,6] streamed back-to-back -> three consecutive step cycles, done pulses 1 cycle after the last step, result=32, buffer still holds [1,2,3] in order.
REQ-040 start with length=0 -> done on the next cycle, result=0, no buf_read_en or weight_ready ever asserted.
REQ-041 length=4, weight_valid dropped for 3 cycles after step 2 -> busy stays 1, no strobes during the gap, result correct after step 4, error=0.
REQ-042 TIMEOUT=8, length=2, one step then weight_valid held 0 -> done with error=1 after 8 stall cycles, result=partial sum; the next start clears error.
REQ-043 Accumulator wrap: mac_sum values 0x7FFFFFFF then 1 -> result=0x80000000.
REQ-044 Reset or abort asserted after the 2nd of 5 steps -> IDLE next cycle, no done pulse, and a new start runs a full 5-step product correctly.
